ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit for the sail-core pipeline. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and buffers returned instructions in a small FIFO for decode. It sits directly downstream of the next-PC 2-to-1 mux: the mux output arrives as `redirect_pc` and the mux select as `redirect`. On a redirect, the unit discards stale work and restarts fetch at the new address.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: fetch FIFO entries; power of two, 2..8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `redirect`  in  1  load `redirect_pc` as the next fetch address and flush.
- `redirect_pc`  in  32  redirect target, from the next-PC mux output.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  32  read address; word aligned.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  read data valid; one pulse per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `fetch_valid`  out  1  FIFO head valid.
- `fetch_pc`  out  32  PC of the head instruction.
- `fetch_instr`  out  32  head instruction word.
- `fetch_ready`  in  1  decode consumes the head.

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - FIFO of {pc, instr} with `count`.
  - FSM with states ISSUE, WAIT, DROP.
- At most one request is outstanding at a time.
- ISSUE:
  - `imem_req_valid` = (`count` < DEPTH); `imem_req_addr` = `pc`.
  - On handshake: `req_pc` <= `pc`, `pc` <= `pc` + 4 (mod 2^32), go to WAIT.
- WAIT:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: push {`req_pc`, `imem_rsp_data`} into the FIFO, go to ISSUE.
- DROP:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: discard the data, go to ISSUE.
- Redirect has the highest priority and applies in every state:
  - `pc` <= {`redirect_pc`[31:2], 2'b00}; misaligned targets are truncated.
  - FIFO flushed (`count` <= 0); a same-cycle pop and push are both cancelled.
  - Next state:
    - ISSUE with a same-cycle handshake -> DROP, since the accepted request is stale.
    - ISSUE with no handshake -> ISSUE.
    - WAIT with a same-cycle `imem_rsp_valid` -> ISSUE, and the response is discarded.
    - WAIT with no response -> DROP.
    - DROP with a same-cycle response -> ISSUE, otherwise stay in DROP.
- FIFO:
  - `fetch_valid` = (`count` != 0).
  - Pop on `fetch_valid` && `fetch_ready`.
  - Push and pop in the same cycle are allowed; `count` is unchanged and order is preserved.
  - Overflow is impossible because issue requires a free slot.
- `fetch_pc` and `fetch_instr` are forced to 0 whenever `fetch_valid` = 0.
- `imem_rsp_valid` is ignored in ISSUE, including stray responses after a mid-operation reset.
- `imem_req_addr` is held stable while `imem_req_valid` && !`imem_req_ready`.

## Timing
- Reset values:
  - `pc` = RESET_PC, state = ISSUE, `count` = 0.
  - `imem_req_valid` = 0 while `rst_n` = 0; `fetch_valid` = 0; `fetch_pc` = 0; `fetch_instr` = 0.
  - `imem_req_addr` = RESET_PC.
- First request is asserted in the first cycle after `rst_n` deasserts.
- Latency:
  - Request accepted at edge T; `imem_rsp_valid` no earlier than cycle T+1.
  - A response sampled at edge R gives `fetch_valid` = 1 from R (registered push).
  - Back-to-back throughput with a 1-cycle memory is one instruction per 2 cycles.
- Redirect sampled at edge T:
  - `fetch_valid` = 0 after T.
  - If the next state is ISSUE, `imem_req_addr` = redirect target in the cycle after T.
- Full FIFO:
  - `imem_req_valid` stays low until a pop.
  - A pop at edge T allows `imem_req_valid` = 1 in the cycle after T.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Asynchronous reset mid-WAIT/DROP: immediate return to reset values; the outstanding response is dropped via the ISSUE ignore rule.

## Test plan
- Reset with RESET_PC = 32'h100 and a 1-cycle memory, `fetch_ready` = 1 -> requests 0x100, 0x104, 0x108; outputs {0x100, word0}, {0x104, word1}, {0x108, word2} in order.
- `fetch_ready` = 0 with DEPTH = 2 -> exactly 2 entries buffered and `imem_req_valid` low; raise `fetch_ready` for one cycle -> one pop, then one new request.
- Redirect to 32'h200 while in WAIT, with the response two cycles later -> stale data never appears; next request is 0x200 and the first output is {0x200, …}.
- Redirect to 32'h303 in the same cycle as an ISSUE handshake -> DROP; next request is 0x300 after the stale response; the FIFO is empty in between.
- Start at RESET_PC = 32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert `rst_n` low mid-WAIT, release it, then deliver the stale response -> response ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: program counter, single-outstanding imem read channel,
// and a small {pc, instr} FIFO feeding decode. Redirect flushes and restarts fetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        fetch_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_nxt;
  logic [31:0]     r_req_pc;
  logic            r_req_valid;
  logic            w_req_valid_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic            w_hs;
  logic            w_push;
  logic            w_pop;

  logic [31:0]     r_pc_q  [DEPTH];
  logic [31:0]     r_ins_q [DEPTH];

  assign w_hs = r_req_valid && imem_req_ready;

  // Next-state, next-pc and FIFO occupancy; redirect overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_push          = 1'b0;
    w_pop           = (r_count != '0) && fetch_ready;
    w_count_nxt     = r_count;
    w_req_valid_nxt = 1'b0;

    case (r_state)
      S_ISSUE: begin
        if (w_hs) begin
          w_state_nxt = S_WAIT;
          w_pc_nxt    = r_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) w_state_nxt = S_ISSUE;
      end
      default: w_state_nxt = S_ISSUE;
    endcase

    if (redirect) begin
      w_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      case (r_state)
        S_ISSUE: w_state_nxt = w_hs ? S_DROP : S_ISSUE;
        S_WAIT,
        S_DROP:  w_state_nxt = imem_rsp_valid ? S_ISSUE : S_DROP;
        default: w_state_nxt = S_ISSUE;
      endcase
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    w_req_valid_nxt = (w_state_nxt == S_ISSUE) && (w_count_nxt < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ISSUE;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_count     <= w_count_nxt;
      if (w_hs) r_req_pc <= r_pc;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  // FIFO payload storage; contents are only observable while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]  <= r_req_pc;
      r_ins_q[r_wr_ptr] <= imem_rsp_data;
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign fetch_valid    = (r_count != '0);
  assign fetch_pc       = fetch_valid ? r_pc_q[r_rd_ptr]  : 32'h0;
  assign fetch_instr    = fetch_valid ? r_ins_q[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit: a RESET_PC=0x100 instance plus a
// RESET_PC=0xFFFF_FFF8 instance driven with identical inputs to cover PC wrap.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        fetch_ready;

  logic        req_valid,  req_valid2;
  logic [31:0] req_addr,   req_addr2;
  logic        fvalid,     fvalid2;
  logic [31:0] fpc,        fpc2;
  logic [31:0] finstr,     finstr2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .fetch_valid(fvalid), .fetch_pc(fpc), .fetch_instr(finstr), .fetch_ready(fetch_ready)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .fetch_valid(fvalid2), .fetch_pc(fpc2), .fetch_instr(finstr2), .fetch_ready(fetch_ready)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        fr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic [31:0] e_addr2;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wrap instance's fetch_pc differs from the main one only before the first redirect.
  function automatic logic [31:0] wrap_pc(input logic [31:0] p);
    if (p != 32'h0 && p < 32'h200) return p - 32'h108;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs observed in a cycle, then inputs applied for the following edge.
    tv[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 32'hFFFF_FFF8, 1'b0, 32'h0,   32'h0};
    tv[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0100, 1'b1, 1'b0, 32'h104, 32'hFFFF_FFFC, 1'b0, 32'h0,   32'h0};
    tv[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 32'hFFFF_FFFC, 1'b1, 32'h100, 32'hD000_0100};
    tv[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0104, 1'b1, 1'b0, 32'h108, 32'h0,         1'b0, 32'h0,   32'h0};
    tv[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h108, 32'h0,         1'b1, 32'h104, 32'hD000_0104};
    tv[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0108, 1'b1, 1'b0, 32'h10C, 32'h4,         1'b0, 32'h0,   32'h0};
    tv[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10C, 32'h4,         1'b1, 32'h108, 32'hD000_0108};
    tv[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_010C, 1'b0, 1'b0, 32'h110, 32'h8,         1'b1, 32'h108, 32'hD000_0108};
    tv[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h110, 32'h8,         1'b1, 32'h108, 32'hD000_0108};
    tv[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h110, 32'h8,         1'b1, 32'h108, 32'hD000_0108};
    tv[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h110, 32'h8,         1'b1, 32'h10C, 32'hD000_010C};
    tv[11] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h114, 32'hC,         1'b1, 32'h10C, 32'hD000_010C};
    tv[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h200, 32'h200,       1'b0, 32'h0,   32'h0};
    tv[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h200, 32'h200,       1'b0, 32'h0,   32'h0};
    tv[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 32'h200,       1'b0, 32'h0,   32'h0};
    tv[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0200, 1'b1, 1'b0, 32'h204, 32'h204,       1'b0, 32'h0,   32'h0};
    tv[16] = '{1'b1, 32'h303, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 32'h204,       1'b1, 32'h200, 32'hD000_0200};
    tv[17] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h300, 32'h300,       1'b0, 32'h0,   32'h0};
    tv[18] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hBAD0_0204, 1'b1, 1'b0, 32'h300, 32'h300,       1'b0, 32'h0,   32'h0};
    tv[19] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h300, 32'h300,       1'b0, 32'h0,   32'h0};
    tv[20] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0300, 1'b1, 1'b0, 32'h304, 32'h304,       1'b0, 32'h0,   32'h0};
    tv[21] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h304, 32'h304,       1'b1, 32'h300, 32'hD000_0300};
    tv[22] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h304, 32'h304,       1'b1, 32'h300, 32'hD000_0300};
    tv[23] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h304, 32'h304,       1'b0, 32'h0,   32'h0};
    tv[24] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h304, 32'h304,       1'b0, 32'h0,   32'h0};

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'h0; fetch_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset req_valid", 32'(req_valid), 32'h0);
    chk("reset req_addr",  req_addr,  32'h100);
    chk("reset req_addr2", req_addr2, 32'hFFFF_FFF8);
    chk("reset fetch_valid", 32'(fvalid), 32'h0);
    chk("reset fetch_pc",  fpc,    32'h0);
    chk("reset fetch_instr", finstr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d req_valid", i),   32'(req_valid),  32'(tv[i].e_rv));
      chk($sformatf("v%0d req_addr", i),    req_addr,        tv[i].e_addr);
      chk($sformatf("v%0d req_valid2", i),  32'(req_valid2), 32'(tv[i].e_rv));
      chk($sformatf("v%0d req_addr2", i),   req_addr2,       tv[i].e_addr2);
      chk($sformatf("v%0d fetch_valid", i), 32'(fvalid),     32'(tv[i].e_fv));
      chk($sformatf("v%0d fetch_pc", i),    fpc,             tv[i].e_pc);
      chk($sformatf("v%0d fetch_instr", i), finstr,          tv[i].e_ins);
      chk($sformatf("v%0d fetch_valid2", i), 32'(fvalid2),   32'(tv[i].e_fv));
      chk($sformatf("v%0d fetch_pc2", i),   fpc2,            wrap_pc(tv[i].e_pc));
      chk($sformatf("v%0d fetch_instr2", i), finstr2,        tv[i].e_ins);
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      req_ready   = tv[i].rdy;
      rsp_valid   = tv[i].rsp_v;
      rsp_data    = tv[i].rsp_d;
      fetch_ready = tv[i].fr;
    end

    // Reset asserted while a request is outstanding, stale response after release.
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    chk("midwait req_valid", 32'(req_valid), 32'h0);
    chk("midwait req_addr",  req_addr, 32'h308);
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst req_valid", 32'(req_valid), 32'h0);
    chk("async rst req_addr",  req_addr,  32'h100);
    chk("async rst req_addr2", req_addr2, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hBAD0_0304;
    @(negedge clk);
    chk("restart req_valid",   32'(req_valid), 32'h1);
    chk("restart req_addr",    req_addr, 32'h100);
    chk("restart fetch_valid", 32'(fvalid), 32'h0);
    rsp_valid   = 1'b0;
    req_ready   = 1'b1;
    fetch_ready = 1'b0;
    @(negedge clk);
    chk("restart wait req_valid", 32'(req_valid), 32'h0);
    chk("restart wait req_addr",  req_addr, 32'h104);
    rsp_valid = 1'b1;
    rsp_data  = 32'hD000_0100;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("restart fetch_valid1", 32'(fvalid), 32'h1);
    chk("restart fetch_pc",     fpc,    32'h100);
    chk("restart fetch_instr",  finstr, 32'hD000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
